// File: rtl/ntt_bfu_pkg.sv
// ntt_bfu_pkg: shared widths, latencies and mode encodings for the NTT butterfly
package ntt_bfu_pkg;
  localparam int DW_DEF = 16;
  localparam int MM_LAT = 6;
  localparam int BFU_LAT = MM_LAT + 1;
  typedef enum logic {MODE_CT = 1'b0, MODE_GS = 1'b1} mode_e;
endpackage

// File: rtl/ntt_dly.sv
// ntt_dly: generic W-wide, N-deep DFF delay chain
module ntt_dly #(
  parameter int W = 16,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [N-1:0][W-1:0] sr_q, sr_d;
  // shift one stage per cycle, newest entry at index 0
  always_comb begin
    sr_d[0] = d;
    for (int i = 1; i < N; i++) sr_d[i] = sr_q[i-1];
  end
  // chain registers, cleared on reset so in-flight data is discarded
  always_ff @(posedge clk or posedge rst)
    if (rst) sr_q <= '0;
    else sr_q <= sr_d;
  assign q = sr_q[N-1];
endmodule

// File: rtl/ntt_mod_addsub.sv
// ntt_mod_addsub: combinational (a+b) mod p and (a-b) mod p for operands in [0,p)
module ntt_mod_addsub #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] p,
  output logic [DW-1:0] sum,
  output logic [DW-1:0] dif
);
  logic [DW:0] s;
  // one conditional correction each way keeps results in [0,p)
  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    sum = s >= {1'b0, p} ? DW'(s - {1'b0, p}) : s[DW-1:0];
    dif = a < b ? a - b + p : a - b;
  end
endmodule

// File: rtl/ntt_mont_mul.sv
// ntt_mont_mul: pipelined Montgomery multiply r = a*b*2^-DW mod p, fixed 6-cycle latency
module ntt_mont_mul #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] p,
  input  logic [DW-1:0] p_neg,
  input  logic [DW-1:0] mu,
  output logic [DW-1:0] r
);
  logic [2*DW-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d, mp3_q, mp3_d;
  logic [DW-1:0] m2_q, m2_d, r5_q, r5_d, r6_q, r6_d;
  logic [DW:0] u4_q, u4_d;
  logic [2*DW:0] s4;
  // product, reduction factor m, m*p, exact division by R, final correction, output stage
  always_comb begin
    t1_d = (2*DW)'(a) * (2*DW)'(b);
    t2_d = t1_q;
    m2_d = t1_q[DW-1:0] * mu;
    t3_d = t2_q;
    mp3_d = (2*DW)'(m2_q) * (2*DW)'(p);
    s4 = {1'b0, t3_q} + {1'b0, mp3_q};
    u4_d = (DW+1)'(s4 >> DW);
    r5_d = u4_q >= {1'b0, p} ? u4_q[DW-1:0] + p_neg : u4_q[DW-1:0];
    r6_d = r5_q;
  end
  // pipeline registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      t1_q <= '0;
      t2_q <= '0;
      m2_q <= '0;
      t3_q <= '0;
      mp3_q <= '0;
      u4_q <= '0;
      r5_q <= '0;
      r6_q <= '0;
    end else begin
      t1_q <= t1_d;
      t2_q <= t2_d;
      m2_q <= m2_d;
      t3_q <= t3_d;
      mp3_q <= mp3_d;
      u4_q <= u4_d;
      r5_q <= r5_d;
      r6_q <= r6_d;
    end
  assign r = r6_q;
endmodule

// File: rtl/ntt_bfu.sv
// ntt_bfu: pipelined CT/GS NTT butterfly around a shared Montgomery multiplier
module ntt_bfu
  import ntt_bfu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          mode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] p,
  input  logic [DW-1:0] p_neg,
  input  logic [DW-1:0] mu,
  output logic          out_valid,
  output logic [DW-1:0] x,
  output logic [DW-1:0] y,
  output logic          idle
);
  localparam int CW = $clog2(BFU_LAT + 1);
  logic gs, v6, m6, ov_q, ov_d;
  logic [DW-1:0] hs, hd, ts, td, mm_r, as6, x_q, x_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign gs = mode == MODE_GS;
  // GS sum/difference are formed on entry so the single multiplier sees every op in its issue
  // cycle; the output register then supplies the extra stage, keeping both modes at MM_LAT+1
  // and letting CT and GS ops share the multiplier back-to-back without collision.
  ntt_mod_addsub #(.DW(DW)) u_head (.a(a), .b(b), .p(p), .sum(hs), .dif(hd));
  ntt_mont_mul #(.DW(DW)) u_mm (
    .clk(clk), .rst(rst), .a(gs ? hd : b), .b(w), .p(p), .p_neg(p_neg), .mu(mu), .r(mm_r)
  );
  ntt_dly #(.W(DW+2), .N(MM_LAT)) u_dly (
    .clk(clk), .rst(rst), .d({in_valid, mode, gs ? hs : a}), .q({v6, m6, as6})
  );
  ntt_mod_addsub #(.DW(DW)) u_tail (.a(as6), .b(mm_r), .p(p), .sum(ts), .dif(td));
  // output mux by the delayed mode bit; results hold when no op arrives
  always_comb begin
    x_d = v6 ? (m6 ? as6 : ts) : x_q;
    y_d = v6 ? (m6 ? mm_r : td) : y_q;
    ov_d = v6;
    cnt_d = cnt_q + CW'(in_valid) - CW'(ov_q);
  end
  // output and in-flight count registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      ov_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      ov_q <= ov_d;
      cnt_q <= cnt_d;
    end
  assign x = x_q;
  assign y = y_q;
  assign out_valid = ov_q;
  assign idle = cnt_q == '0;
endmodule

// File: tb/tb_ntt_bfu.sv
// tb_ntt_bfu: directed and randomized checks of ntt_bfu against a modular-arithmetic model
module tb_ntt_bfu;
  localparam longint P = 12289;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mode = 1'b0;
  logic [15:0] a = '0, b = '0, w = '0, p, p_neg, mu;
  logic out_valid, idle;
  logic [15:0] x, y;
  logic [15:0] lx = '0, ly = '0;
  int checks = 0, failures = 0;
  longint rinv = 0;
  longint qx[$], qy[$];

  ntt_bfu #(.DW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .a(a), .b(b), .w(w),
    .p(p), .p_neg(p_neg), .mu(mu), .out_valid(out_valid), .x(x), .y(y), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint mmr(longint u, longint v);
    return (u * v % P) * rinv % P;
  endfunction

  function automatic longint ref_x(logic m, longint ra, longint rb, longint rw);
    return m ? (ra + rb) % P : (ra + mmr(rb, rw)) % P;
  endfunction

  function automatic longint ref_y(logic m, longint ra, longint rb, longint rw);
    return m ? mmr((ra - rb + P) % P, rw) : (ra - mmr(rb, rw) + P) % P;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic m, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [15:0] tw, input logic [15:0] ex, input logic [15:0] ey);
    in_valid = 1'b1; mode = m; a = ta; b = tb; w = tw;
    tick;
    in_valid = 1'b0;
    chk({tag, "_busy"}, idle, 1'b0);
    repeat (5) tick;
    chk({tag, "_early"}, out_valid, 1'b0);
    tick;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_x"}, x, ex);
    chk({tag, "_y"}, y, ey);
    lx = ex; ly = ey;
    tick;
    chk({tag, "_idle"}, idle, 1'b1);
    chk({tag, "_hold_x"}, x, ex);
  endtask

  task automatic run(input string tag, input int n, input int g, input bit alt);
    int issued, emitted;
    bit ev;
    logic m;
    logic [15:0] ra, rb, rw;
    for (int c = 0; c < (n - 1) * g + 9; c++) begin
      ra = 16'($urandom_range(0, int'(P) - 1));
      rb = 16'($urandom_range(0, int'(P) - 1));
      rw = 16'($urandom_range(0, int'(P) - 1));
      m = alt ? 1'((c / g) % 2) : 1'($urandom_range(0, 1));
      in_valid = (c % g == 0) && (c / g < n);
      mode = m; a = ra; b = rb; w = rw;
      if (in_valid) begin
        qx.push_back(ref_x(m, ra, rb, rw));
        qy.push_back(ref_y(m, ra, rb, rw));
      end
      tick;
      ev = c >= 6 && (c - 6) % g == 0 && (c - 6) / g < n;
      chk({tag, "_valid"}, out_valid, ev);
      if (ev) begin
        lx = 16'(qx.pop_front());
        ly = 16'(qy.pop_front());
        chk({tag, "_x"}, x, lx);
        chk({tag, "_y"}, y, ly);
      end else begin
        chk({tag, "_hold_x"}, x, lx);
        chk({tag, "_hold_y"}, y, ly);
      end
      issued = (c / g + 1 < n) ? c / g + 1 : n;
      emitted = c < 7 ? 0 : (((c - 7) / g + 1 < n) ? (c - 7) / g + 1 : n);
      chk({tag, "_idle"}, idle, issued == emitted);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    longint inv;
    inv = P;
    repeat (4) inv = (inv * (2 - P * inv)) & 64'hFFFF;
    p = 16'(P);
    p_neg = 16'(65536 - P);
    mu = 16'((65536 - inv) & 64'hFFFF);
    for (longint k = 1; k < P; k++) if ((65536 * k) % P == 1) rinv = k;
    tick;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_idle", idle, 1'b1);
    chk("reset_x", x, 16'd0);
    chk("reset_y", y, 16'd0);
    rst = 1'b0;
    tick;
    single("ct_basic", 1'b0, 16'd100, 16'd30, 16'd4091, 16'd130, 16'd70);
    single("ct_addwrap", 1'b0, 16'd12000, 16'd1000, 16'd4091, 16'd711, 16'd11000);
    single("ct_subwrap", 1'b0, 16'd10, 16'd30, 16'd4091, 16'd40, 16'd12269);
    single("gs_basic", 1'b1, 16'd100, 16'd30, 16'd4091, 16'd130, 16'd70);
    single("gs_subwrap", 1'b1, 16'd5, 16'd9, 16'd4091, 16'd14, 16'd12285);
    single("ct_mont", 1'b0, 16'd7, 16'd2, 16'd3, 16'(ref_x(1'b0, 7, 2, 3)), 16'(ref_y(1'b0, 7, 2, 3)));
    run("b2b", 20, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; mode = 1'(i % 2); a = 16'd1000; b = 16'd2000; w = 16'd4091;
      tick;
    end
    in_valid = 1'b0;
    chk("rst_pre_busy", idle, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async_idle", idle, 1'b1);
    chk("rst_async_valid", out_valid, 1'b0);
    chk("rst_async_x", x, 16'd0);
    chk("rst_async_y", y, 16'd0);
    tick;
    rst = 1'b0;
    lx = '0; ly = '0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("rst_discard_valid", out_valid, 1'b0);
      chk("rst_discard_idle", idle, 1'b1);
    end
    single("post_rst", 1'b1, 16'd12288, 16'd1, 16'd4091, 16'd0, 16'd12287);
    run("sparse", 6, 3, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
